case_sel_arbiter: RTL and testbench

CASE_SEL_ARBITER -- requirements
Module: case_sel_arbiter

---
 rtl/case_sel_arbiter.sv | 133 +++++++++++++
 tb/tb_case_sel_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/case_sel_arbiter.sv
`default_nettype none
// ============================================================================
// case_sel_arbiter : 4-way round-robin arbiter with bounded grant tenure
//                    and a registered sel-decoded output mux.
// Revision         : 1.0
// ============================================================================
module case_sel_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       a,
    output logic       b
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] C_TENURE_LOAD = 4'(HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] w_winner;
    logic       w_found;
    logic [1:0] w_idx;

    // Rotating priority: first set request strictly after the last winner.
    always_comb begin
        w_winner = last_q;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last_q + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        a_d     = 1'b0;
        b_d     = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
                if (w_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << w_winner;
                    sel_d   = w_winner;
                    busy_d  = 1'b1;
                    cnt_d   = C_TENURE_LOAD;
                    last_d  = w_winner;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (cnt_q == 4'd0)) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase

        // Mux outputs follow the next-state select so they line up with gnt.
        if (state_d == GRANT) begin
            case (sel_d)
                2'd0:    begin a_d = 1'b0;      b_d = 1'b1;      end
                2'd1:    begin a_d = 1'b1;      b_d = 1'b0;      end
                default: begin a_d = d[sel_d]; b_d = d[sel_d]; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign a    = a_q;
    assign b    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_case_sel_arbiter.sv
`default_nettype none
// ============================================================================
// tb_case_sel_arbiter : directed self-checking bench for case_sel_arbiter
// Revision            : 1.0
// ============================================================================
module tb_case_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       a;
    logic       b;

    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [1:0] sel1;
    logic       busy1;
    logic       a1;
    logic       b1;

    int n_chk;
    int n_pass;

    case_sel_arbiter #(.HOLD(4)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .d    (d),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .a    (a),
        .b    (b)
    );

    case_sel_arbiter #(.HOLD(1)) u_dut_h1 (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req1),
        .d    (4'b0000),
        .gnt  (gnt1),
        .sel  (sel1),
        .busy (busy1),
        .a    (a1),
        .b    (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b1;
        req    = 4'b0000;
        req1   = 4'b0000;
        d      = 4'b0000;

        // Reset state
        #12;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_sel",  32'(sel),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ab",   32'({a, b}), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single requester 0, held for the full tenure
        req = 4'b0001;
        tick();
        chk("r0_gnt",  32'(gnt),  32'h1);
        chk("r0_sel",  32'(sel),  32'h0);
        chk("r0_ab",   32'({a, b}), 32'h1);
        chk("r0_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r0_hold_busy", 32'(busy), 32'h1);
        end
        tick();
        chk("r0_release_busy", 32'(busy), 32'h0);
        chk("r0_release_gnt",  32'(gnt),  32'h0);
        chk("r0_idle_sel",     32'(sel),  32'h0);
        req = 4'b0000;
        tick();

        // All requesting: rotation 0,1,2,3,0 with one idle cycle between
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
            chk("rr_sel", 32'(sel), 32'(g % 4));
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("rr_hold", 32'(gnt), 32'(4'b0001 << (g % 4)));
            end
            tick();
            chk("rr_idle", 32'({gnt, busy}), 32'h0);
        end
        req = 4'b0000;
        tick();

        // Requester 2: a/b follow d[2] one cycle later; requester 1 gives a=1,b=0
        do_reset();
        req = 4'b0100;
        d   = 4'b0000;
        tick();
        chk("r2_gnt", 32'(gnt), 32'h4);
        chk("r2_ab0", 32'({a, b}), 32'h0);
        d = 4'b0100;
        tick();
        chk("r2_ab1", 32'({a, b}), 32'h3);
        d = 4'b1011;
        tick();
        chk("r2_ab_other_bits", 32'({a, b}), 32'h0);
        req = 4'b0000;
        d   = 4'b0100;
        tick();
        chk("r2_drop_busy", 32'(busy), 32'h0);
        chk("r2_idle_ab",   32'({a, b}), 32'h0);
        chk("r2_idle_sel",  32'(sel),  32'h2);
        req = 4'b0010;
        tick();
        chk("r1_gnt", 32'(gnt), 32'h2);
        chk("r1_ab",  32'({a, b}), 32'h2);
        req = 4'b0000;
        tick();

        // Requester 1 drops early; requester 3 pending gets the next grant
        do_reset();
        req = 4'b1010;
        d   = 4'b1000;
        tick();
        chk("drop_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("drop_gnt1_hold", 32'(gnt), 32'h2);
        req = 4'b1000;
        tick();
        chk("drop_release", 32'({gnt, busy}), 32'h0);
        tick();
        chk("drop_regrant", 32'(gnt), 32'h8);
        chk("drop_sel",     32'(sel), 32'h3);
        chk("drop_ab",      32'({a, b}), 32'h3);
        req = 4'b0000;
        d   = 4'b0000;
        tick();

        // Asynchronous reset mid-grant, arbitration restarts at requester 0
        do_reset();
        req = 4'b0010;
        tick();
        chk("ar_pre_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_outs", 32'({gnt, sel, busy, a, b}), 32'h0);
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("ar_restart", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        tick();

        // HOLD=1: alternating single-cycle grants
        do_reset();
        req1 = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("h1_gnt",  32'(gnt1),  (i % 2 == 0) ? 32'h8 : 32'h0);
            chk("h1_busy", 32'(busy1), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        req1 = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
